pc_unit: RTL and testbench
==========================

# pc_unit

Program-counter stage at the head of the fetch pipeline. It holds the fetch PC, advances it by 4, and applies redirects from decode (branch outcome from the Branch comparator plus target, jumps), from exceptions and from eret. Because MIPS has a branch delay slot, the instruction already at `pc` when a redirect arrives in decode is always fetched. Redirects that arrive while fetch is stalled are buffered until fetch can advance.

## Interface
Parameters:
- RESET_PC, 32'hBFC0_0000, PC loaded by reset
- EXC_VECTOR, 32'hBFC0_0380, PC loaded on exception

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- stall  input  1  fetch cannot advance this cycle (imem wait or hazard)
- takeBranch  input  1  branch taken, from the branch comparator, already qualified by braEnable
- braTarget  input  32  branch target, computed in decode
- jumpEnable  input  1  j/jal/jr/jalr in decode
- jumpTarget  input  32  jump target
- excEnable  input  1  exception flush request
- eretEnable  input  1  eret flush request
- epc  input  32  return address for eret
- pc  output  32  current fetch address
- fetchValid  output  1  pc is a valid fetch request
- addrErr  output  1  pc is misaligned; only with PC_ALIGN_CHECK_EN

## Operation
- Redirect source priority, highest first: exc, eret, jump, branch. takeBranch and jumpEnable together is illegal and never occurs; if it does, jump wins.
- Per-cycle next-PC selection when stall=0:
  - Pending redirect buffered, with no exc or eret this cycle: pc <= pendTarget, and the pending buffer clears.
  - exc: pc <= EXC_VECTOR.
  - eret: pc <= epc.
  - jump or branch: pc <= target. The delay-slot instruction is the current pc and is fetched this cycle.
  - Otherwise: pc <= pc + 4, with 32-bit wrap-around (32'hFFFF_FFFC -> 0).
- When stall=1, pc holds. Any redirect is written into a one-entry pending buffer (pendValid, pendTarget, pendIsExc), subject to:
  - exc/eret overwrite any pending entry.
  - A branch/jump does not overwrite a pending exc/eret entry (it is dropped).
  - A branch/jump overwrites a pending branch/jump entry (latest wins).
- Redirect arriving in the same cycle that stall deasserts: it is applied directly under the priority above. An exc/eret beats a pending branch; a branch/jump replaces a pending branch.
- fetchValid is 0 in the cycle rst is sampled high and 1 from the next cycle on. It does not drop on stall; the consumer ignores it while stall=1.
- State: reset state RESET (fetchValid=0), then RUN. Pending-buffer states are EMPTY and FULL. FULL->EMPTY happens on the first stall=0 cycle or on rst.

## Timing
- Reset: pc=RESET_PC, fetchValid=0, pendValid=0, addrErr=0, all visible the cycle after rst is sampled. rst asserted mid-stall discards any pending redirect.
- Redirect latency: a redirect sampled with stall=0 appears on pc in the next cycle (1 cycle).
- Redirect sampled during a stall appears on pc in the cycle after the first stall=0 edge.
- pc is a register output. There is no combinational path from any input to pc or fetchValid.

## Configuration
- Macro PC_ALIGN_CHECK_EN.
- Defined:
  - addrErr = (pc[1:0] != 0) & fetchValid, registered alongside pc.
  - The misaligned pc is still presented.
  - excEnable from downstream is expected to follow and takes normal priority.
- Undefined:
  - The addrErr port is absent.
  - Targets are used unchanged, with no alignment logic.

## Structure
- Shared package, in the existing CPU constants include:
  - RESET_PC and EXC_VECTOR defaults.
  - A 2-bit redirect-kind encoding (NONE, BRANCH, ERET, EXC) used for pendKind.
- One sub-module, pc_redirect_buf: the pending buffer with its overwrite-priority rules. pc_unit keeps the PC register and the next-PC mux.

## Test plan
- Reset then 3 free-running cycles: pc = BFC00000, BFC00004, BFC00008, BFC0000C; fetchValid 0 then 1.
- pc=00400010, takeBranch=1, braTarget=00400100, stall=0: next pc=00400100; the 00400010 fetch is not squashed.
- stall=1 for 3 cycles, branch to 00400200 in the first stall cycle, stall=0 on cycle 4: pc holds, then pc=00400200 after cycle 4.
- During a stall, branch to 00400300 then excEnable: after release pc=BFC00380. A further branch during the stall is dropped.
- pc=FFFFFFFC, no redirect: next pc=00000000. eretEnable with epc=00400020: pc=00400020 next cycle.
- PC_ALIGN_CHECK_EN defined, jump to 00400102: pc=00400102 with addrErr=1; a following excEnable gives pc=BFC00380 with addrErr=0.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// Shared CPU constants for the fetch PC stage: reset/exception vectors and redirect kinds.
package pc_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned KIND_W = 2;

    localparam logic [XLEN-1:0] RESET_PC_DEF   = 32'hBFC0_0000;
    localparam logic [XLEN-1:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

    // Redirect kinds; jumps and branches share BRANCH since they obey the same rules.
    localparam logic [KIND_W-1:0] KIND_NONE   = 2'd0;
    localparam logic [KIND_W-1:0] KIND_BRANCH = 2'd1;
    localparam logic [KIND_W-1:0] KIND_ERET   = 2'd2;
    localparam logic [KIND_W-1:0] KIND_EXC    = 2'd3;

    // Flush-class redirects (exc/eret) outrank branches and jumps.
    function automatic logic kind_is_flush(input logic [KIND_W-1:0] k);
        return (k == KIND_ERET) || (k == KIND_EXC);
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry buffer holding a redirect that arrived while fetch was stalled.
// Flush redirects overwrite anything; branch/jump overwrites only a branch/jump.
module pc_redirect_buf
    import pc_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [KIND_W-1:0] kind_in,
    input  logic [XLEN-1:0]   target_in,
    output logic              pend_valid,
    output logic [XLEN-1:0]   pend_target,
    output logic [KIND_W-1:0] pend_kind,
    output logic              pend_is_exc
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]        state_q, state_nxt;
    logic [XLEN-1:0]   target_q, target_nxt;
    logic [KIND_W-1:0] kind_q, kind_nxt;

    // Buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            target_q <= '0;
            kind_q   <= KIND_NONE;
        end else begin
            state_q  <= state_nxt;
            target_q <= target_nxt;
            kind_q   <= kind_nxt;
        end
    end

    // Capture/overwrite rules while stalled; drain on the first unstalled cycle.
    always_comb begin
        state_nxt  = state_q;
        target_nxt = target_q;
        kind_nxt   = kind_q;
        if (!stall) begin
            state_nxt = ST_EMPTY;
            kind_nxt  = KIND_NONE;
        end else if (kind_is_flush(kind_in)) begin
            state_nxt  = ST_FULL;
            target_nxt = target_in;
            kind_nxt   = kind_in;
        end else if (kind_in == KIND_BRANCH &&
                     !(state_q == ST_FULL && kind_is_flush(kind_q))) begin
            state_nxt  = ST_FULL;
            target_nxt = target_in;
            kind_nxt   = kind_in;
        end
    end

    assign pend_valid  = (state_q == ST_FULL);
    assign pend_target = target_q;
    assign pend_kind   = kind_q;
    assign pend_is_exc = (state_q == ST_FULL) && kind_is_flush(kind_q);

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter: advances by 4 and applies exc/eret/jump/branch redirects,
// buffering redirects that arrive during a stall.
// Optional misalignment flag (addrErr) built when PC_ALIGN_CHECK_EN is defined.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        takeBranch,
    input  logic [31:0] braTarget,
    input  logic        jumpEnable,
    input  logic [31:0] jumpTarget,
    input  logic        excEnable,
    input  logic        eretEnable,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    output logic        fetchValid
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic        addrErr
`endif
);

    localparam logic [0:0] ST_RESET = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]        state_q;
    logic [XLEN-1:0]   pc_q, pc_nxt;
    logic [KIND_W-1:0] cur_kind;
    logic [XLEN-1:0]   cur_target;
    logic              pend_valid;
    logic [XLEN-1:0]   pend_target;
    logic [KIND_W-1:0] pend_kind;
    logic              pend_is_exc;

    // Resolve this cycle's redirect by priority: exc, eret, jump, branch.
    always_comb begin
        cur_kind   = KIND_NONE;
        cur_target = '0;
        if (excEnable) begin
            cur_kind   = KIND_EXC;
            cur_target = EXC_VECTOR;
        end else if (eretEnable) begin
            cur_kind   = KIND_ERET;
            cur_target = epc;
        end else if (jumpEnable) begin
            cur_kind   = KIND_BRANCH;
            cur_target = jumpTarget;
        end else if (takeBranch) begin
            cur_kind   = KIND_BRANCH;
            cur_target = braTarget;
        end
    end

    pc_redirect_buf u_buf (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .kind_in     (cur_kind),
        .target_in   (cur_target),
        .pend_valid  (pend_valid),
        .pend_target (pend_target),
        .pend_kind   (pend_kind),
        .pend_is_exc (pend_is_exc)
    );

    // Next-PC mux; a live flush beats the buffer, a buffered flush beats a live branch.
    always_comb begin
        pc_nxt = pc_q;
        if (!stall) begin
            if (kind_is_flush(cur_kind)) begin
                pc_nxt = cur_target;
            end else if (pend_valid && (pend_is_exc || cur_kind == KIND_NONE)) begin
                pc_nxt = pend_target;
            end else if (cur_kind == KIND_BRANCH) begin
                pc_nxt = cur_target;
            end else begin
                pc_nxt = XLEN'(pc_q + 32'd4);
            end
        end
    end

    // PC and run-state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RESET;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= ST_RUN;
            pc_q    <= pc_nxt;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic addr_err_q;

    // Misalignment flag registered alongside the PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= (pc_nxt[1:0] != 2'b00);
        end
    end

    assign addrErr = addr_err_q;
`endif

    assign pc         = pc_q;
    assign fetchValid = (state_q == ST_RUN);

    // pend_kind is exported for observability; pend_is_exc carries what the mux needs.
    logic unused_kind;
    assign unused_kind = ^pend_kind;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with a scoreboard queue of expected pc/fetchValid.
module tb_pc_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic        fv;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        takeBranch;
    logic [31:0] braTarget;
    logic        jumpEnable;
    logic [31:0] jumpTarget;
    logic        excEnable;
    logic        eretEnable;
    logic [31:0] epc;
    logic [31:0] pc;
    logic        fetchValid;
`ifdef PC_ALIGN_CHECK_EN
    logic        addrErr;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    pc_unit dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .takeBranch (takeBranch),
        .braTarget  (braTarget),
        .jumpEnable (jumpEnable),
        .jumpTarget (jumpTarget),
        .excEnable  (excEnable),
        .eretEnable (eretEnable),
        .epc        (epc),
        .pc         (pc),
        .fetchValid (fetchValid)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .addrErr    (addrErr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge.
    task automatic drive(input logic r, input logic s, input logic br, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt, input logic e,
                         input logic er, input logic [31:0] ep);
        @(negedge clk);
        rst = r; stall = s; takeBranch = br; braTarget = bt;
        jumpEnable = j; jumpTarget = jt; excEnable = e; eretEnable = er; epc = ep;
    endtask

    // Push the expectation for this cycle, advance one edge, then pop and compare.
    task automatic tick(input string tag, input logic [31:0] epc_exp, input logic fv_exp);
        exp_t e;
        sb.push_back('{pc: epc_exp, fv: fv_exp});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        assert (pc === e.pc) else begin
            failures++;
            $error("FAIL %s pc observed=%08h expected=%08h", tag, pc, e.pc);
        end
        checks++;
        assert (fetchValid === e.fv) else begin
            failures++;
            $error("FAIL %s fetchValid observed=%0b expected=%0b", tag, fetchValid, e.fv);
        end
`ifdef PC_ALIGN_CHECK_EN
        checks++;
        assert (addrErr === ((e.pc[1:0] != 2'b00) && e.fv)) else begin
            failures++;
            $error("FAIL %s addrErr observed=%0b expected=%0b", tag, addrErr,
                   (e.pc[1:0] != 2'b00) && e.fv);
        end
`endif
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; takeBranch = 1'b0; braTarget = '0;
        jumpEnable = 1'b0; jumpTarget = '0; excEnable = 1'b0; eretEnable = 1'b0; epc = '0;

        // Reset and free-run
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);                  tick("reset", 32'hBFC00000, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);                  tick("run1", 32'hBFC00004, 1'b1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);                  tick("run2", 32'hBFC00008, 1'b1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);                  tick("run3", 32'hBFC0000C, 1'b1);

        // Jump then taken branch, one-cycle latency
        drive(0, 0, 0, 0, 1, 32'h00400010, 0, 0, 0);       tick("jump", 32'h00400010, 1'b1);
        drive(0, 0, 1, 32'h00400100, 0, 0, 0, 0, 0);       tick("branch", 32'h00400100, 1'b1);

        // Branch buffered across a 3-cycle stall
        drive(0, 1, 1, 32'h00400200, 0, 0, 0, 0, 0);       tick("stall_br1", 32'h00400100, 1'b1);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);                  tick("stall_br2", 32'h00400100, 1'b1);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);                  tick("stall_br3", 32'h00400100, 1'b1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);                  tick("release_br", 32'h00400200, 1'b1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);                  tick("after_br", 32'h00400204, 1'b1);

        // Exception overwrites pending branch; later branch dropped
        drive(0, 1, 1, 32'h00400300, 0, 0, 0, 0, 0);       tick("st_br", 32'h00400204, 1'b1);
        drive(0, 1, 0, 0, 0, 0, 1, 0, 0);                  tick("st_exc", 32'h00400204, 1'b1);
        drive(0, 1, 1, 32'h00400400, 0, 0, 0, 0, 0);       tick("st_drop", 32'h00400204, 1'b1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);                  tick("release_exc", 32'hBFC00380, 1'b1);

        // Wrap-around and eret
        drive(0, 0, 0, 0, 1, 32'hFFFFFFFC, 0, 0, 0);       tick("to_top", 32'hFFFFFFFC, 1'b1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);                  tick("wrap", 32'h00000000, 1'b1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h00400020);       tick("eret", 32'h00400020, 1'b1);

        // Redirect in the release cycle
        drive(0, 1, 1, 32'h00400500, 0, 0, 0, 0, 0);       tick("st_br_b", 32'h00400020, 1'b1);
        drive(0, 0, 0, 0, 1, 32'h00400600, 0, 0, 0);       tick("rel_jump_wins", 32'h00400600, 1'b1);
        drive(0, 1, 0, 0, 0, 0, 1, 0, 0);                  tick("st_exc_b", 32'h00400600, 1'b1);
        drive(0, 0, 1, 32'h00400700, 0, 0, 0, 0, 0);       tick("rel_pend_exc_wins", 32'hBFC00380, 1'b1);
        drive(0, 1, 1, 32'h00400700, 0, 0, 0, 0, 0);       tick("st_br_c", 32'hBFC00380, 1'b1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h00400040);       tick("rel_eret_wins", 32'h00400040, 1'b1);

        // Reset mid-stall discards pending redirect
        drive(0, 1, 1, 32'h00400800, 0, 0, 0, 0, 0);       tick("st_br_d", 32'h00400040, 1'b1);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);                  tick("rst_stall", 32'hBFC00000, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);                  tick("post_rst", 32'hBFC00004, 1'b1);

        // Same-cycle priority
        drive(0, 0, 1, 32'h00400900, 1, 32'h00400A00, 1, 1, 32'h00400B00);
                                                           tick("prio_exc", 32'hBFC00380, 1'b1);
        drive(0, 0, 1, 32'h00400900, 1, 32'h00400A00, 0, 1, 32'h00400B00);
                                                           tick("prio_eret", 32'h00400B00, 1'b1);
        drive(0, 0, 1, 32'h00400900, 1, 32'h00400A00, 0, 0, 0);
                                                           tick("prio_jump", 32'h00400A00, 1'b1);

        // Misaligned target presented, then exception recovers
        drive(0, 0, 0, 0, 1, 32'h00400102, 0, 0, 0);       tick("misalign", 32'h00400102, 1'b1);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);                  tick("misalign_exc", 32'hBFC00380, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
